rtc_bus_responder: RTL

- Synthesizable slave model of the multiplexed-address/data RTC device; it sits at the far end of the RTC control-signal generator's bus (a_d, cs, wr, rd, ad).
- Latches addresses, writes data, serves reads, and keeps BCD seconds/minutes/hours advancing on an external 1 Hz tick.
- Used in system benches and on-board loopback in place of the physical RTC chip.

---
 rtl/rtc_bus_pkg.sv | 29 ++
 rtl/rtc_bus_responder_if.sv | 23 ++
 rtl/rtc_bcd_counter.sv | 32 +++
 rtl/rtc_bus_responder.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/rtc_bus_pkg.sv
// Shared definitions for the RTC bus responder: FSM encoding, time-register
// map, BCD limits and the value returned for unimplemented addresses.
package rtc_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        WRITE = 2'd2,
        READ  = 2'd3
    } state_t;

    // Default time-register map; minutes and hours follow seconds.
    localparam logic [7:0] RTC_SEC_ADDR  = 8'h21;
    localparam logic [7:0] RTC_MIN_ADDR  = 8'h22;
    localparam logic [7:0] RTC_HOUR_ADDR = 8'h23;

    // Highest legal BCD value of each time field before wrapping to 00.
    localparam logic [7:0] BCD_MAX_MS = 8'h59;
    localparam logic [7:0] BCD_MAX_HR = 8'h23;

    // Read data for an address beyond the implemented register file.
    localparam logic [7:0] RD_OOR_VAL = 8'hFF;

    // True when both nibbles hold a decimal digit.
    function automatic logic bcd_valid(input logic [7:0] v);
        return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9);
    endfunction

endpackage

// File: rtl/rtc_bus_responder_if.sv
// Multiplexed address/data RTC bus. The master drives phase, strobes and
// ad_in; the slave returns read data together with its output enable.
interface rtc_bus_responder_if #(
    parameter int DATA_W = 8
) ();
    logic              a_d;
    logic              cs_n;
    logic              wr_n;
    logic              rd_n;
    logic [DATA_W-1:0] ad_in;
    logic [DATA_W-1:0] ad_out;
    logic              ad_oe;

    modport master (
        output a_d, cs_n, wr_n, rd_n, ad_in,
        input  ad_out, ad_oe
    );

    modport slave (
        input  a_d, cs_n, wr_n, rd_n, ad_in,
        output ad_out, ad_oe
    );
endinterface

// File: rtl/rtc_bcd_counter.sv
// One BCD time field: increments on inc, wraps to 00 after MAX with a carry,
// and forces any non-BCD value back to 00 without a carry.
module rtc_bcd_counter
    import rtc_bus_pkg::*;
#(
    parameter logic [7:0] MAX = BCD_MAX_MS
) (
    input  logic [7:0] val,
    input  logic       inc,
    output logic [7:0] nxt,
    output logic       carry
);

    // Next value of the field and its carry into the next field.
    always_comb begin
        nxt   = val;
        carry = 1'b0;
        if (inc) begin
            if (!bcd_valid(val)) begin
                nxt = 8'h00;
            end else if (val >= MAX) begin
                nxt   = 8'h00;
                carry = 1'b1;
            end else if (val[3:0] == 4'd9) begin
                nxt = {val[7:4] + 4'd1, 4'd0};
            end else begin
                nxt = {val[7:4], val[3:0] + 4'd1};
            end
        end
    end

endmodule

// File: rtl/rtc_bus_responder.sv
// Slave model of the multiplexed-bus RTC chip: latches addresses, accepts
// writes, serves reads and advances BCD seconds/minutes/hours on a 1 Hz tick.
module rtc_bus_responder
    import rtc_bus_pkg::*;
#(
    parameter int         ADDR_W    = 8,
    parameter int         DATA_W    = 8,
    parameter int         REG_DEPTH = 64,
    parameter logic [7:0] SEC_ADDR  = RTC_SEC_ADDR
) (
    input  logic                clk,
    input  logic                reset,
    rtc_bus_responder_if.slave  bus,
    input  logic                tick_1hz,
    output logic [ADDR_W-1:0]   addr_q,
    output logic                proto_err
);

    localparam int IDX_W  = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;
    localparam int SEC_I  = int'(SEC_ADDR);
    localparam int MIN_I  = SEC_I + int'(RTC_MIN_ADDR - RTC_SEC_ADDR);
    localparam int HOUR_I = SEC_I + int'(RTC_HOUR_ADDR - RTC_SEC_ADDR);

    state_t state_q, state_d;
    logic   wr_q, rd_q;
    logic   wr_fall, wr_rise, rd_fall, both_low;
    logic   addr_ld, wr_en, err_set, oe_set, oe_clr;

    logic [DATA_W-1:0] regs [REG_DEPTH];
    logic              in_range;
    logic [IDX_W-1:0]  addr_idx;
    logic [DATA_W-1:0] rd_data;

    logic [7:0] sec_nxt, min_nxt, hour_nxt;
    logic       sec_carry, min_carry, hour_carry_unused;
    logic       sec_wr, min_wr, min_inc, hour_inc;

    assign wr_fall  = wr_q & ~bus.wr_n;
    assign wr_rise  = ~wr_q & bus.wr_n;
    assign rd_fall  = rd_q & ~bus.rd_n;
    assign both_low = ~bus.cs_n & ~bus.wr_n & ~bus.rd_n;

    assign in_range = (int'(addr_q) < REG_DEPTH);
    assign addr_idx = addr_q[IDX_W-1:0];
    assign rd_data  = in_range ? regs[addr_idx] : DATA_W'(RD_OOR_VAL);

    // State register and one-cycle strobe history for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            wr_q    <= 1'b1;
            rd_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            wr_q    <= bus.wr_n;
            rd_q    <= bus.rd_n;
        end
    end

    // Bus protocol decode: next state plus one-cycle datapath commands.
    always_comb begin
        state_d = state_q;
        addr_ld = 1'b0;
        wr_en   = 1'b0;
        err_set = 1'b0;
        oe_set  = 1'b0;
        oe_clr  = 1'b0;
        case (state_q)
            IDLE: begin
                if (both_low) begin
                    err_set = 1'b1;
                end else if (!bus.cs_n && wr_fall) begin
                    state_d = bus.a_d ? WRITE : ADDR;
                end else if (!bus.cs_n && bus.a_d && rd_fall) begin
                    state_d = READ;
                end
            end
            ADDR: begin
                if (bus.cs_n || both_low) begin
                    err_set = 1'b1;
                    state_d = IDLE;
                end else if (wr_rise) begin
                    addr_ld = 1'b1;
                    state_d = IDLE;
                end
            end
            WRITE: begin
                if (bus.cs_n || both_low) begin
                    err_set = 1'b1;
                    state_d = IDLE;
                end else if (wr_rise) begin
                    wr_en   = in_range;
                    err_set = ~in_range;
                    state_d = IDLE;
                end
            end
            READ: begin
                if (bus.cs_n || both_low) begin
                    err_set = 1'b1;
                    oe_clr  = 1'b1;
                    state_d = IDLE;
                end else if (bus.rd_n) begin
                    oe_clr  = 1'b1;
                    state_d = IDLE;
                end else begin
                    oe_set  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Address latch, sticky error flag and registered read port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q     <= '0;
            proto_err  <= 1'b0;
            bus.ad_out <= '0;
            bus.ad_oe  <= 1'b0;
        end else begin
            if (addr_ld) addr_q <= ADDR_W'(bus.ad_in);
            if (err_set) proto_err <= 1'b1;
            if (oe_set) begin
                bus.ad_out <= rd_data;
                bus.ad_oe  <= 1'b1;
            end
            if (oe_clr) bus.ad_oe <= 1'b0;
        end
    end

    // A bus write to a time field overrides its tick update and blocks its carry.
    assign sec_wr   = wr_en && (int'(addr_q) == SEC_I);
    assign min_wr   = wr_en && (int'(addr_q) == MIN_I);
    assign min_inc  = sec_carry & ~sec_wr;
    assign hour_inc = min_carry & ~min_wr;

    rtc_bcd_counter #(.MAX(BCD_MAX_MS)) u_sec (
        .val   (regs[SEC_I][7:0]),
        .inc   (tick_1hz),
        .nxt   (sec_nxt),
        .carry (sec_carry)
    );

    rtc_bcd_counter #(.MAX(BCD_MAX_MS)) u_min (
        .val   (regs[MIN_I][7:0]),
        .inc   (min_inc),
        .nxt   (min_nxt),
        .carry (min_carry)
    );

    rtc_bcd_counter #(.MAX(BCD_MAX_HR)) u_hour (
        .val   (regs[HOUR_I][7:0]),
        .inc   (hour_inc),
        .nxt   (hour_nxt),
        .carry (hour_carry_unused)
    );

    // Register file: tick advances the time fields, a bus write then takes priority.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < REG_DEPTH; i++) regs[i] <= '0;
        end else begin
            if (tick_1hz) begin
                regs[SEC_I]  <= DATA_W'(sec_nxt);
                regs[MIN_I]  <= DATA_W'(min_nxt);
                regs[HOUR_I] <= DATA_W'(hour_nxt);
            end
            if (wr_en) regs[addr_idx] <= bus.ad_in;
        end
    end

endmodule
